// File: rtl/y_datapath_core.sv
// Single-cycle MIPS-32 ID/EX/DM slice: 32x32 register file, ALU and word-addressed data memory.
// All read paths are combinational and state updates on clk; optional write-to-read bypass under YDP_RF_BYPASS_EN.
module y_datapath_core #(
  parameter int DM_AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins,
  input  logic [31:0] wd,
  input  logic        RegDst,
  input  logic        RegWrite,
  input  logic        ALUSrc,
  input  logic [2:0]  op,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] imm,
  output logic [25:0] jTarget,
  output logic [31:0] z,
  output logic        zero,
  output logic [31:0] memOut
);

  logic [31:0] regs [32];
  logic [31:0] mem  [2**DM_AW];

  logic [4:0]       rsIdx, rtIdx, destIdx;
  logic             wrActive;
  logic [31:0]      aluB;
  logic [DM_AW-1:0] memAddr;
  logic             memInRange;

  assign rsIdx    = ins[25:21];
  assign rtIdx    = ins[20:16];
  assign destIdx  = RegDst ? ins[15:11] : ins[20:16];
  assign wrActive = RegWrite && !rst && (destIdx != 5'd0);

  assign imm     = {{16{ins[15]}}, ins[15:0]};
  assign jTarget = ins[25:0];

  // R0 is never written, so the reset loop and read mux are the only places it appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (wrActive) begin
      regs[destIdx] <= wd;
    end
  end

  always_comb begin
    rd1 = (rsIdx == 5'd0) ? 32'd0 : regs[rsIdx];
    rd2 = (rtIdx == 5'd0) ? 32'd0 : regs[rtIdx];
`ifdef YDP_RF_BYPASS_EN
    if (wrActive && (rsIdx == destIdx)) rd1 = wd;
    if (wrActive && (rtIdx == destIdx)) rd2 = wd;
`endif
  end

  assign aluB = ALUSrc ? imm : rd2;

  always_comb begin
    z = 32'd0;
    case (op)
      3'b000: z = rd1 & aluB;
      3'b001: z = rd1 | aluB;
      3'b010: z = rd1 + aluB;
      3'b110: z = rd1 - aluB;
      3'b111: z = {31'd0, $signed(rd1) < $signed(aluB)};
      default: z = 32'd0;
    endcase
  end

  assign zero = (z == 32'd0);

  // Byte offset z[1:0] is dropped; anything above the memory span is out of range.
  assign memAddr    = z[DM_AW+1:2];
  assign memInRange = (z[31:DM_AW+2] == '0);

  // Memory is deliberately not reset so preloaded contents survive rst.
  always_ff @(posedge clk) begin
    if (MemWrite && !rst && memInRange) mem[memAddr] <= rd2;
  end

  assign memOut = (MemRead && memInRange) ? mem[memAddr] : 32'd0;

  logic unusedBits;
  assign unusedBits = ^{z[1:0], ins[31:26]};

endmodule

// File: tb/tb_y_datapath_core.sv
// Scoreboard bench for y_datapath_core: expectations are queued with the stimulus and drained once outputs settle.
module tb_y_datapath_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins, wd;
  logic        RegDst, RegWrite, ALUSrc, MemRead, MemWrite;
  logic [2:0]  op;
  logic [31:0] rd1, rd2, imm, z, memOut;
  logic [25:0] jTarget;
  logic        zero;

  always #5 clk = ~clk;

  y_datapath_core #(.DM_AW(10)) dut (
    .clk(clk), .rst(rst), .ins(ins), .wd(wd),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .op(op),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .rd1(rd1), .rd2(rd2), .imm(imm), .jTarget(jTarget),
    .z(z), .zero(zero), .memOut(memOut)
  );

  localparam int SEL_RD1 = 0, SEL_RD2 = 1, SEL_IMM = 2, SEL_JT = 3,
                 SEL_Z = 4, SEL_ZERO = 5, SEL_MEM = 6;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sbItem_t;

  sbItem_t sbQ[$];
  int testsRun = 0;
  int testsFailed = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      SEL_RD1:  return rd1;
      SEL_RD2:  return rd2;
      SEL_IMM:  return imm;
      SEL_JT:   return {6'd0, jTarget};
      SEL_Z:    return z;
      SEL_ZERO: return {31'd0, zero};
      default:  return memOut;
    endcase
  endfunction

  task automatic expectOut(input string tag, input int sel, input logic [31:0] exp);
    sbItem_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = exp;
    sbQ.push_back(it);
  endtask

  // Outputs are combinational: let inputs settle, then compare everything queued.
  task automatic drain();
    sbItem_t it;
    #2;
    while (sbQ.size() > 0) begin
      it = sbQ.pop_front();
      checkVal(it.tag, probe(it.sel), it.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'h00, 6'h20};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] im);
    return {opc, rs, rt, im};
  endfunction

  // Register write through the rt destination with bench-chosen data.
  task automatic writeReg(input logic [4:0] rt, input logic [31:0] data);
    ins = iType(6'h08, 5'd0, rt, 16'd0);
    RegDst = 1'b0; RegWrite = 1'b1; wd = data;
    tick();
    RegWrite = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ins = 32'd0; wd = 32'd0;
    RegDst = 1'b0; RegWrite = 1'b0; ALUSrc = 1'b0; op = 3'b010;
    MemRead = 1'b0; MemWrite = 1'b0;
    tick();
    rst = 1'b0;

    // Post-reset reads
    ins = rType(5'd1, 5'd2, 5'd3); RegDst = 1'b1; ALUSrc = 1'b0; op = 3'b010;
    expectOut("rst_rd1", SEL_RD1, 32'd0);
    expectOut("rst_rd2", SEL_RD2, 32'd0);
    expectOut("rst_z", SEL_Z, 32'd0);
    expectOut("rst_zero", SEL_ZERO, 32'd1);
    drain();

    // addi $1,$0,5 with write-back of the ALU result
    ins = iType(6'h08, 5'd0, 5'd1, 16'd5); RegDst = 1'b0; ALUSrc = 1'b1; op = 3'b010;
    RegWrite = 1'b1; wd = 32'd5;
    expectOut("addi_imm", SEL_IMM, 32'd5);
    expectOut("addi_z", SEL_Z, 32'd5);
    drain();
    tick();
    RegWrite = 1'b0;
    ins = iType(6'h08, 5'd1, 5'd0, 16'd0);
    expectOut("addi_rd1", SEL_RD1, 32'd5);
    drain();

    writeReg(5'd2, 32'd7);

    // ALU ops with $1=5, $2=7, imm=0xFFFC
    ins = iType(6'h08, 5'd1, 5'd2, 16'hFFFC);
    expectOut("sext_imm", SEL_IMM, 32'hFFFF_FFFC);
    expectOut("jtarget", SEL_JT, 32'h0022_FFFC);
    expectOut("rd1_5", SEL_RD1, 32'd5);
    expectOut("rd2_7", SEL_RD2, 32'd7);
    drain();
    ALUSrc = 1'b0;
    op = 3'b110; expectOut("sub_z", SEL_Z, 32'hFFFF_FFFE); expectOut("sub_zero", SEL_ZERO, 32'd0); drain();
    op = 3'b111; expectOut("slt_z", SEL_Z, 32'd1); drain();
    op = 3'b000; expectOut("and_z", SEL_Z, 32'd5); drain();
    op = 3'b001; expectOut("or_z", SEL_Z, 32'd7); drain();
    op = 3'b011; expectOut("undef_z", SEL_Z, 32'd0); expectOut("undef_zero", SEL_ZERO, 32'd1); drain();
    ALUSrc = 1'b1;
    op = 3'b010; expectOut("addimm_z", SEL_Z, 32'd1); drain();
    op = 3'b111; expectOut("sltimm_z", SEL_Z, 32'd0); drain();

    // sw $2,8($0) then reads
    op = 3'b010; ALUSrc = 1'b1;
    ins = iType(6'h2B, 5'd0, 5'd2, 16'd8); MemWrite = 1'b1; MemRead = 1'b0;
    expectOut("sw_addr_z", SEL_Z, 32'd8);
    expectOut("memout_noread", SEL_MEM, 32'd0);
    drain();
    tick();
    MemWrite = 1'b0; MemRead = 1'b1;
    expectOut("lw_after_sw", SEL_MEM, 32'd7); drain();
    MemRead = 1'b0;
    expectOut("memread_off", SEL_MEM, 32'd0); drain();

    // Simultaneous read/write: pre-edge word visible, new word after the edge
    ins = iType(6'h2B, 5'd0, 5'd1, 16'd8); MemWrite = 1'b1; MemRead = 1'b1;
    expectOut("rw_pre_edge", SEL_MEM, 32'd7); drain();
    tick();
    MemWrite = 1'b0;
    expectOut("rw_post_edge", SEL_MEM, 32'd5); drain();
    ins = iType(6'h23, 5'd0, 5'd0, 16'd9);
    expectOut("byte_offset_ignored", SEL_MEM, 32'd5); drain();

    // Writes to R0 are discarded
    ins = rType(5'd0, 5'd0, 5'd0); RegDst = 1'b1; RegWrite = 1'b1; wd = 32'h1234;
    tick();
    RegWrite = 1'b0;
    expectOut("r0_rd1", SEL_RD1, 32'd0);
    expectOut("r0_rd2", SEL_RD2, 32'd0);
    drain();

    // Out-of-range address aliasing onto word 0 must not write it
    MemRead = 1'b0; ALUSrc = 1'b1; op = 3'b010;
    ins = iType(6'h2B, 5'd0, 5'd1, 16'd0); MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
    writeReg(5'd5, 32'h1000_0000);
    ins = iType(6'h2B, 5'd5, 5'd2, 16'd0); MemWrite = 1'b1; MemRead = 1'b1;
    expectOut("oor_z", SEL_Z, 32'h1000_0000);
    expectOut("oor_read", SEL_MEM, 32'd0);
    drain();
    tick();
    MemWrite = 1'b0;
    ins = iType(6'h23, 5'd0, 5'd0, 16'd0);
    expectOut("oor_no_write", SEL_MEM, 32'd5); drain();

    // rst beats RegWrite on the same edge; memory survives
    writeReg(5'd6, 32'h55);
    rst = 1'b1; ins = iType(6'h08, 5'd0, 5'd6, 16'd3); RegDst = 1'b0; RegWrite = 1'b1; wd = 32'hABCD;
    op = 3'b111; ALUSrc = 1'b1; MemRead = 1'b0;
    tick();
    rst = 1'b0; RegWrite = 1'b0;
    expectOut("rst_slt_imm", SEL_Z, 32'd1);
    expectOut("rst_slt_zero", SEL_ZERO, 32'd0);
    drain();
    ins = iType(6'h08, 5'd6, 5'd1, 16'd0);
    expectOut("rst_wins_rd1", SEL_RD1, 32'd0);
    expectOut("rst_clears_rd2", SEL_RD2, 32'd0);
    drain();
    op = 3'b010; MemRead = 1'b1; ins = iType(6'h23, 5'd0, 5'd0, 16'd8);
    expectOut("mem_survives_rst", SEL_MEM, 32'd5); drain();
    MemRead = 1'b0;

    // Same-cycle write/read of $4
    writeReg(5'd4, 32'd3);
    ins = iType(6'h08, 5'd4, 5'd4, 16'd0); RegDst = 1'b0; RegWrite = 1'b1; wd = 32'd9;
`ifdef YDP_RF_BYPASS_EN
    expectOut("bypass_rd1", SEL_RD1, 32'd9);
`else
    expectOut("nobypass_rd1", SEL_RD1, 32'd3);
`endif
    drain();
    tick();
    RegWrite = 1'b0;
    expectOut("after_write_rd1", SEL_RD1, 32'd9); drain();

    if (sbQ.size() != 0) checkVal("scoreboard_empty", sbQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
